// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported program/data memory.
// Optional round-robin arbitration: define MEM_ARBITER_ROUND_ROBIN_EN (default: port 0 priority).
module mem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_clock,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_to,
  input  logic [DATA_W-1:0] mem_from
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StAck} state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_to_q, mem_to_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
  logic                mem_clock_q, mem_clock_d;
  logic                mem_write_q, mem_write_d;
  logic                p0_ack_q, p0_ack_d;
  logic                p1_ack_q, p1_ack_d;
  logic                sel_p1;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic                last_grant_q, last_grant_d;

  // On contention the port that did not win last time goes next.
  always_comb begin
    if (p0_req && p1_req) sel_p1 = ~last_grant_q;
    else                  sel_p1 = p1_req;
  end
`else
  always_comb sel_p1 = ~p0_req;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    op_write_d = op_write_q;
    mem_addr_d = mem_addr_q;
    mem_to_d   = mem_to_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      StIdle: begin
        if (p0_req || p1_req) begin
          grant_d    = sel_p1;
          op_write_d = sel_p1 ? p1_write : p0_write;
          mem_addr_d = sel_p1 ? p1_addr  : p0_addr;
          mem_to_d   = sel_p1 ? p1_wdata : p0_wdata;
          state_d    = StSetup;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
          last_grant_d = sel_p1;
`endif
        end
      end
      StSetup:  state_d = StStrobe;
      StStrobe: begin
        state_d = StAck;
        if (!op_write_q) begin
          if (grant_q) p1_rdata_d = mem_from;
          else         p0_rdata_d = mem_from;
        end
      end
      StAck:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Outputs are registered, so decode them from the next state.
    mem_clock_d = (state_d == StStrobe);
    mem_write_d = (state_d != StIdle) && op_write_d;
    p0_ack_d    = (state_d == StAck) && !grant_d;
    p1_ack_d    = (state_d == StAck) && grant_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      op_write_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_to_q    <= '0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      mem_clock_q <= 1'b0;
      mem_write_q <= 1'b0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      op_write_q  <= op_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_to_q    <= mem_to_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      mem_clock_q <= mem_clock_d;
      mem_write_q <= mem_write_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
    end
  end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // Reset to port 1 so port 0 wins the first contention.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_grant_q <= 1'b1;
    else          last_grant_q <= last_grant_d;
  end
`endif

  assign mem_clock = mem_clock_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_to    = mem_to_q;
  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus multi-cycle corner sequences.
// Expectations follow MEM_ARBITER_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       p0_req, p0_write, p1_req, p1_write;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_ack, p1_ack;
  logic [7:0] p0_rdata, p1_rdata;
  logic       mem_clock, mem_write;
  logic [7:0] mem_addr, mem_to, mem_from;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .p0_req   (p0_req),
    .p0_write (p0_write),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_ack   (p0_ack),
    .p0_rdata (p0_rdata),
    .p1_req   (p1_req),
    .p1_write (p1_write),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_ack   (p1_ack),
    .p1_rdata (p1_rdata),
    .mem_clock(mem_clock),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_to   (mem_to),
    .mem_from (mem_from)
  );

  // Memory model: preloaded contents until a location is written.
  logic [7:0] mem_w   [256];
  bit         written [256];

  always @(posedge mem_clock) begin
    if (mem_write) begin
      mem_w[mem_addr]   <= mem_to;
      written[mem_addr] <= 1'b1;
    end
  end

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h00:   return 8'h33;
      8'h01:   return 8'h11;
      8'h02:   return 8'h22;
      8'h21:   return 8'h99;
      default: return 8'h00;
    endcase
  endfunction

  assign mem_from = written[mem_addr] ? mem_w[mem_addr] : init_val(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    p0_req  = 1'b0;
    p1_req  = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Single-port access; starts on a negedge with the FSM idle, returns one idle cycle later.
  task automatic do_access(input bit port, input bit wr, input logic [7:0] addr,
                           input logic [7:0] wdata, input string tag, output logic [7:0] rd);
    int cnt;
    bit got;
    if (!port) begin
      p0_write = wr; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end else begin
      p1_write = wr; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 20) begin
      @(negedge clock);
      cnt++;
      if (cnt == 1) begin
        chk({tag, " setup mem_addr"}, 32'(mem_addr), 32'(addr));
        chk({tag, " setup mem_write"}, 32'(mem_write), 32'(wr));
        chk({tag, " setup mem_clock"}, 32'(mem_clock), 32'd0);
      end
      if (cnt == 2) chk({tag, " strobe mem_clock"}, 32'(mem_clock), 32'd1);
      if (port ? p1_ack : p0_ack) begin
        got = 1'b1;
        if (!port) p0_req = 1'b0;
        else       p1_req = 1'b0;
      end
    end
    chk({tag, " ack latency"}, 32'(cnt), 32'd3);
    rd = port ? p1_rdata : p0_rdata;
    @(negedge clock);
    chk({tag, " idle strobe"}, {31'd0, mem_clock | mem_write}, 32'd0);
  endtask

  typedef struct {
    bit         port;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic [7:0] exp_other;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [7:0] rd;
    int         cnt, a0, a1, nack, last_ack, nack1;
    bit         ackp;

    vecs[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'h5A, 8'h00, 8'hA5};
    vecs[3] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A, 8'hA5};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h33, 8'h5A};
    vecs[5] = '{1'b1, 1'b1, 8'h00, 8'h44, 8'h5A, 8'h33};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h44, 8'h5A};

    p0_write = 1'b0; p0_addr = 8'h00; p0_wdata = 8'h00;
    p1_write = 1'b0; p1_addr = 8'h00; p1_wdata = 8'h00;
    p0_req = 1'b0; p1_req = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    chk("reset mem_clock", 32'(mem_clock), 32'd0);
    chk("reset mem_write", 32'(mem_write), 32'd0);
    chk("reset acks", {30'd0, p0_ack, p1_ack}, 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_to", 32'(mem_to), 32'd0);
    chk("reset rdata", {16'd0, p0_rdata, p1_rdata}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Contention right after reset: port 0 first, port 1 four cycles later.
    p0_write = 1'b0; p0_addr = 8'h01;
    p1_write = 1'b0; p1_addr = 8'h02;
    p0_req = 1'b1; p1_req = 1'b1;
    cnt = 0; a0 = 0; a1 = 0;
    while ((a0 == 0 || a1 == 0) && cnt < 20) begin
      @(negedge clock);
      cnt++;
      if (p0_ack) begin
        a0 = cnt; p0_req = 1'b0;
        chk("contend p0_rdata", 32'(p0_rdata), 32'h11);
        chk("contend p1 idle at p0 ack", 32'(p1_ack), 32'd0);
      end
      if (p1_ack) begin
        a1 = cnt; p1_req = 1'b0;
        chk("contend p1_rdata", 32'(p1_rdata), 32'h22);
        chk("contend p0_rdata kept", 32'(p0_rdata), 32'h11);
      end
    end
    chk("contend p0 ack cycle", 32'(a0), 32'd3);
    chk("contend p1 ack cycle", 32'(a1), 32'd7);
    @(negedge clock);

    do_reset();
    for (int i = 0; i < 7; i++) begin
      do_access(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i), rd);
      chk($sformatf("vec%0d rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d other rdata", i),
          32'(vecs[i].port ? p0_rdata : p1_rdata), 32'(vecs[i].exp_other));
    end

    // Both ports requesting continuously for 8 accesses.
    do_reset();
    p0_write = 1'b0; p0_addr = 8'h01;
    p1_write = 1'b0; p1_addr = 8'h02;
    p0_req = 1'b1; p1_req = 1'b1;
    cnt = 0; nack = 0; nack1 = 0; last_ack = 0;
    while (nack < 8 && cnt < 60) begin
      @(negedge clock);
      cnt++;
      if (p0_ack || p1_ack) begin
        ackp = p1_ack;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        chk($sformatf("fair grant %0d", nack), 32'(ackp), 32'(nack % 2));
`else
        chk($sformatf("fair grant %0d", nack), 32'(ackp), 32'd0);
`endif
        if (nack > 0) chk($sformatf("fair gap %0d", nack), 32'(cnt - last_ack), 32'd4);
        if (ackp) nack1++;
        last_ack = cnt;
        nack++;
        if (nack == 8) begin
          p0_req = 1'b0; p1_req = 1'b0;
        end
      end
    end
    chk("fair total acks", 32'(nack), 32'd8);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    chk("fair p1 acks", 32'(nack1), 32'd4);
`else
    chk("fair p1 acks", 32'(nack1), 32'd0);
`endif
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) @(negedge clock);

    // Reset during STROBE of a port 1 read.
    p1_write = 1'b0; p1_addr = 8'h02; p1_req = 1'b1;
    repeat (2) @(negedge clock);
    chk("abort strobe high", 32'(mem_clock), 32'd1);
    reset_n = 1'b0;
    p1_req  = 1'b0;
    #1;
    chk("abort mem_clock", 32'(mem_clock), 32'd0);
    chk("abort p1_ack", 32'(p1_ack), 32'd0);
    chk("abort p1_rdata", 32'(p1_rdata), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    ackp = 1'b0;
    repeat (4) begin
      @(negedge clock);
      ackp = ackp | p1_ack | mem_clock;
    end
    chk("abort quiet after release", 32'(ackp), 32'd0);
    do_access(1'b1, 1'b0, 8'h02, 8'h00, "reissue", rd);
    chk("reissue rdata", 32'(rd), 32'h22);

    // Port 1 holds req through ack; fields changed mid-access and at ack.
    p1_write = 1'b1; p1_addr = 8'h20; p1_wdata = 8'h77; p1_req = 1'b1;
    cnt = 0; nack = 0;
    while (nack < 2 && cnt < 20) begin
      @(negedge clock);
      cnt++;
      if (cnt == 1) begin
        chk("held setup mem_addr", 32'(mem_addr), 32'h20);
        chk("held setup mem_write", 32'(mem_write), 32'd1);
        p1_addr = 8'h55; p1_wdata = 8'hEE;
      end
      if (cnt == 2) begin
        chk("held strobe mem_addr", 32'(mem_addr), 32'h20);
        chk("held strobe mem_to", 32'(mem_to), 32'h77);
      end
      if (cnt == 5) begin
        chk("held 2nd mem_addr", 32'(mem_addr), 32'h21);
        chk("held 2nd mem_write", 32'(mem_write), 32'd0);
      end
      if (p1_ack) begin
        nack++;
        if (nack == 1) begin
          chk("held 1st ack cycle", 32'(cnt), 32'd3);
          p1_addr = 8'h21; p1_write = 1'b0;
        end else begin
          chk("held 2nd ack cycle", 32'(cnt), 32'd7);
          chk("held 2nd rdata", 32'(p1_rdata), 32'h99);
          p1_req = 1'b0;
        end
      end
    end
    chk("held ack count", 32'(nack), 32'd2);
    p1_req = 1'b0;
    @(negedge clock);
    do_access(1'b0, 1'b0, 8'h20, 8'h00, "held verify 20", rd);
    chk("held mem 0x20", 32'(rd), 32'h77);
    do_access(1'b0, 1'b0, 8'h55, 8'h00, "held verify 55", rd);
    chk("held mem 0x55 untouched", 32'(rd), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
